spi_reg_slave: RTL and testbench

Parametrised SPI slave giving the host MCU addressed read/write access to a bank of FPGA registers. It replaces the fixed 16-bit single-word slave with several additions:
- configurable word width, address width and register count;
- all four CPOL/CPHA modes;
- a two-word header+data frame protocol with write strobes, error reporting and optional burst auto-increment.

It sits between the external SPI pins and the command/status register banks, all on SYS_CLK.

---
 rtl/spi_reg_pkg.sv | 33 +++
 rtl/spi_pin_sync.sv | 51 +++++
 rtl/spi_reg_slave.sv | 177 +++++++++++++++++
 tb/tb_spi_reg_slave.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: frame FSM states, SPI mode constants and edge-select helpers for spi_reg_slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    DRAIN
  } state_e;

  localparam int unsigned CPOL_IDLE_LOW  = 0;
  localparam int unsigned CPOL_IDLE_HIGH = 1;
  localparam int unsigned CPHA_LEAD      = 0;
  localparam int unsigned CPHA_TRAIL     = 1;

  typedef struct packed {
    logic lead_rise;    // leading edge is the rising SPI_CLK edge
    logic sample_lead;  // MOSI is sampled on the leading edge
  } edge_sel_t;

  function automatic edge_sel_t edge_select(int unsigned cpol, int unsigned cpha);
    edge_sel_t sel;
    sel.lead_rise   = (cpol != CPOL_IDLE_HIGH);
    sel.sample_lead = (cpha != CPHA_TRAIL);
    return sel;
  endfunction

  // The read/write flag sits in the MSB of the header word.
  function automatic int unsigned w_bit_idx(int unsigned word_w);
    return word_w - 1;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 3-flop synchronisers for SPI_CLK/SSEL/MOSI with leading/trailing
// clock-edge pulses and slave-select start/stop pulses, all in the system clock domain.
module spi_pin_sync
  import spi_reg_pkg::*;
#(
  parameter int unsigned CPOL = CPOL_IDLE_LOW
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic ssel_i,
  input  logic mosi_i,
  output logic lead_o,
  output logic trail_o,
  output logic start_o,
  output logic stop_o,
  output logic mosi_o
);

  localparam edge_sel_t SEL       = edge_select(CPOL, CPHA_LEAD);
  localparam logic      LEAD_RISE = SEL.lead_rise;

  logic [2:0] sclk_q;
  logic [2:0] ssel_q;
  logic [2:0] mosi_q;
  logic       rise;
  logic       fall;

  // Clearing the SSEL history means a select already held low at reset release
  // never looks like a frame start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= '0;
      ssel_q <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      ssel_q <= {ssel_q[1:0], ssel_i};
      mosi_q <= {mosi_q[1:0], mosi_i};
    end
  end

  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign fall    = ~sclk_q[1] & sclk_q[2];
  assign lead_o  = LEAD_RISE ? rise : fall;
  assign trail_o = LEAD_RISE ? fall : rise;
  assign start_o = ~ssel_q[1] & ssel_q[2];
  assign stop_o  = ssel_q[1] & ~ssel_q[2];
  assign mosi_o  = mosi_q[2];

endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave giving header+data addressed access to a register bank.
// Define SPI_REG_AUTOINC_EN for burst frames with address auto-increment.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned CPOL     = CPOL_IDLE_LOW,
  parameter int unsigned CPHA     = CPHA_LEAD
) (
  input  logic                       SYS_CLK,
  input  logic                       RST,
  input  logic                       SPI_CLK,
  input  logic                       SSEL,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic [NUM_REGS*WORD_W-1:0] RD_REGS,
  output logic [NUM_REGS*WORD_W-1:0] WR_REGS,
  output logic [NUM_REGS-1:0]        WR_STROBE,
  output logic                       FRAME_ERR
);

  localparam edge_sel_t   SEL         = edge_select(CPOL, CPHA);
  localparam logic        SAMPLE_LEAD = SEL.sample_lead;
  localparam int unsigned W_BIT       = w_bit_idx(WORD_W);
  localparam int unsigned CNT_W       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned ADDR_SPAN   = 2 ** ADDR_W;

  logic lead;
  logic trail;
  logic start;
  logic stop;
  logic mosi_s;
  logic sample;
  logic shift;

  spi_pin_sync #(
    .CPOL(CPOL)
  ) u_sync (
    .clk_i  (SYS_CLK),
    .rst_i  (RST),
    .sclk_i (SPI_CLK),
    .ssel_i (SSEL),
    .mosi_i (MOSI),
    .lead_o (lead),
    .trail_o(trail),
    .start_o(start),
    .stop_o (stop),
    .mosi_o (mosi_s)
  );

  assign sample = SAMPLE_LEAD ? lead : trail;
  assign shift  = SAMPLE_LEAD ? trail : lead;

  state_e            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [WORD_W-2:0] rx_q;
  logic [WORD_W-1:0] tx_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wr_regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] strobe_q;
  logic              err_q;

  // Unimplemented addresses read back as zero.
  logic [WORD_W-1:0] rd_arr [ADDR_SPAN];

  for (genvar g = 0; g < ADDR_SPAN; g++) begin : g_rd
    if (g < NUM_REGS) begin : g_impl
      assign rd_arr[g] = RD_REGS[g*WORD_W +: WORD_W];
    end else begin : g_pad
      assign rd_arr[g] = '0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_wr
    assign WR_REGS[g*WORD_W +: WORD_W] = wr_regs_q[g];
  end

  logic [WORD_W-1:0] rx_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              last_bit;
  logic [ADDR_W-1:0] hdr_addr;
  logic              addr_ok;
`ifdef SPI_REG_AUTOINC_EN
  logic [ADDR_W-1:0] next_addr;
`endif

  always_comb begin
    rx_d     = {rx_q, mosi_s};
    last_bit = (bit_cnt_q == CNT_W'(WORD_W - 1));
    cnt_d    = bit_cnt_q;
    if (sample) begin
      cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
    end
    hdr_addr = rx_d[ADDR_W-1:0];
    addr_ok  = (32'(addr_q) < NUM_REGS);
`ifdef SPI_REG_AUTOINC_EN
    next_addr = addr_q + ADDR_W'(1);
`endif
  end

  // Word completion is handled before the SSEL stop check so a stop that lands
  // on the final sample edge still commits the word and raises no error.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      strobe_q  <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        wr_regs_q[i] <= '0;
      end
    end else begin
      strobe_q <= '0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= HEADER;
            bit_cnt_q <= '0;
            tx_q      <= '0;
          end
        end
        default: begin
          if (sample) begin
            rx_q      <= rx_d[WORD_W-2:0];
            bit_cnt_q <= cnt_d;
            if (last_bit) begin
              if (state_q == HEADER) begin
                wr_q    <= rx_d[W_BIT];
                addr_q  <= hdr_addr;
                tx_q    <= rd_arr[hdr_addr];
                state_q <= DATA;
              end else if (state_q == DATA) begin
                if (wr_q && addr_ok) begin
                  wr_regs_q[addr_q] <= rx_d;
                  strobe_q[addr_q]  <= 1'b1;
                end else if (!addr_ok) begin
                  err_q <= 1'b1;
                end
`ifdef SPI_REG_AUTOINC_EN
                addr_q <= next_addr;
                tx_q   <= rd_arr[next_addr];
`else
                state_q <= DRAIN;
                tx_q    <= '0;
`endif
              end
            end
          end else if (shift && (bit_cnt_q != '0)) begin
            // Holding TX at count 0 keeps the MSB on MISO for the first data bit.
            tx_q <= {tx_q[WORD_W-2:0], 1'b0};
          end
          if (stop) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            bit_cnt_q <= '0;
            if (cnt_d != '0) begin
              err_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign MISO      = tx_q[W_BIT];
  assign WR_STROBE = strobe_q;
  assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: randomized SPI frames on a mode-0 (40 regs) and a mode-3 (64 regs)
// instance, checked against a frame-level register model. Honours SPI_REG_AUTOINC_EN.
module tb_spi_reg_slave;

  localparam int unsigned WW  = 16;
  localparam int unsigned AW  = 6;
  localparam int unsigned NR0 = 40;
  localparam int unsigned NR1 = 64;
  localparam int          HP  = 8;

`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk0 = 1'b0, sclk1 = 1'b1;
  logic ssel0 = 1'b1, ssel1 = 1'b1;
  logic mosi = 1'b0;
  logic miso0, miso1, ferr0, ferr1;
  logic [NR0*WW-1:0] rd0, wr0;
  logic [NR1*WW-1:0] rd1, wr1;
  logic [NR0-1:0]    strb0;
  logic [NR1-1:0]    strb1;

  always #5 clk = ~clk;

  spi_reg_slave #(.WORD_W(WW), .ADDR_W(AW), .NUM_REGS(NR0), .CPOL(0), .CPHA(0)) dut0 (
    .SYS_CLK(clk), .RST(rst), .SPI_CLK(sclk0), .SSEL(ssel0), .MOSI(mosi), .MISO(miso0),
    .RD_REGS(rd0), .WR_REGS(wr0), .WR_STROBE(strb0), .FRAME_ERR(ferr0)
  );

  spi_reg_slave #(.WORD_W(WW), .ADDR_W(AW), .NUM_REGS(NR1), .CPOL(1), .CPHA(1)) dut1 (
    .SYS_CLK(clk), .RST(rst), .SPI_CLK(sclk1), .SSEL(ssel1), .MOSI(mosi), .MISO(miso1),
    .RD_REGS(rd1), .WR_REGS(wr1), .WR_STROBE(strb1), .FRAME_ERR(ferr1)
  );

  int strb_seen [2][64];
  int err_seen  [2];

  always @(posedge clk) begin
    for (int i = 0; i < int'(NR0); i++) if (strb0[i]) strb_seen[0][i] <= strb_seen[0][i] + 1;
    for (int i = 0; i < int'(NR1); i++) if (strb1[i]) strb_seen[1][i] <= strb_seen[1][i] + 1;
    if (ferr0) err_seen[0] <= err_seen[0] + 1;
    if (ferr1) err_seen[1] <= err_seen[1] + 1;
  end

  logic [15:0] m_rd [2][64];
  logic [15:0] m_wr [2][64];
  int          exp_strb [2][64];
  int          exp_err  [2];
  logic [15:0] tx_w [8];
  logic [15:0] rx_w [8];
  int          errors = 0;
  int          checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nreg(input int dev);
    return (dev == 0) ? int'(NR0) : int'(NR1);
  endfunction

  task automatic drive_rd();
    for (int i = 0; i < int'(NR0); i++) rd0[i*WW +: WW] = m_rd[0][i];
    for (int i = 0; i < int'(NR1); i++) rd1[i*WW +: WW] = m_rd[1][i];
  endtask

  task automatic set_sclk(input int dev, input logic v);
    if (dev == 0) sclk0 = v; else sclk1 = v;
  endtask

  task automatic set_ssel(input int dev, input logic v);
    if (dev == 0) ssel0 = v; else ssel1 = v;
  endtask

  function automatic logic get_miso(input int dev);
    return (dev == 0) ? miso0 : miso1;
  endfunction

  task automatic wait_hp();
    repeat (HP) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 64; i++) m_wr[d][i] = '0;
    @(negedge clk);
    check_eq("rst_wr0_zero", 32'(|wr0), 32'd0);
    check_eq("rst_wr1_zero", 32'(|wr1), 32'd0);
    check_eq("rst_miso0", 32'(miso0), 32'd0);
    check_eq("rst_strb0", 32'(|strb0), 32'd0);
  endtask

  // dev 0 is mode 0 (CPOL=0,CPHA=0); dev 1 is mode 3 (CPOL=1,CPHA=1).
  task automatic spi_xfer(input int dev, input int nbits, input int rst_at);
    logic        pol;
    logic [15:0] w;
    logic        bitv;
    pol = (dev != 0);
    for (int k = 0; k < 8; k++) rx_w[k] = '0;
    set_ssel(dev, 1'b0);
    wait_hp();
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_at) pulse_rst();
      w    = tx_w[b/16];
      bitv = w[15 - b%16];
      if (dev == 0) begin
        mosi = bitv;
        wait_hp();
        rx_w[b/16][15 - b%16] = get_miso(dev);
        set_sclk(dev, ~pol);
        wait_hp();
        set_sclk(dev, pol);
      end else begin
        set_sclk(dev, ~pol);
        mosi = bitv;
        wait_hp();
        rx_w[b/16][15 - b%16] = get_miso(dev);
        set_sclk(dev, pol);
        wait_hp();
      end
    end
    wait_hp();
    set_ssel(dev, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic check_state(input int dev, input string name);
    logic [15:0] got;
    check_eq($sformatf("%s err_cnt%0d", name, dev), err_seen[dev], exp_err[dev]);
    for (int i = 0; i < nreg(dev); i++) begin
      if (dev == 0) got = wr0[i*WW +: WW]; else got = wr1[i*WW +: WW];
      check_eq($sformatf("%s strb%0d[%0d]", name, dev, i), strb_seen[dev][i], exp_strb[dev][i]);
      check_eq($sformatf("%s wr%0d[%0d]", name, dev, i), got, m_wr[dev][i]);
    end
  endtask

  task automatic run_frame(input int dev, input int nbits, input int rst_at, input string name);
    int          nr, nfull, rem, a;
    logic        w;
    logic [15:0] exp_miso [8];
    bit          was_reset;
    nr        = nreg(dev);
    was_reset = (rst_at >= 0) && (rst_at < nbits);
    drive_rd();
    spi_xfer(dev, nbits, rst_at);
    nfull = nbits / 16;
    rem   = nbits % 16;
    for (int k = 0; k < 8; k++) exp_miso[k] = '0;
    if (!was_reset) begin
      if (nfull > 0) begin
        w = tx_w[0][15];
        for (int k = 1; k < nfull; k++) begin
          if (AUTOINC || k == 1) begin
            a = (int'(tx_w[0][5:0]) + k - 1) % 64;
            exp_miso[k] = (a < nr) ? m_rd[dev][a] : 16'h0;
            if (w) begin
              if (a < nr) begin
                m_wr[dev][a] = tx_w[k];
                exp_strb[dev][a]++;
              end else begin
                exp_err[dev]++;
              end
            end else if (a >= nr) begin
              exp_err[dev]++;
            end
          end
        end
      end
      if (rem != 0) exp_err[dev]++;
      for (int k = 0; k < nfull; k++)
        check_eq($sformatf("%s miso%0d word%0d", name, dev, k), rx_w[k], exp_miso[k]);
    end
    check_state(dev, name);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) begin
        m_rd[d][i] = 16'($urandom);
        m_wr[d][i] = '0;
      end
    drive_rd();
    repeat (5) @(negedge clk);
    check_eq("reset_miso0", 32'(miso0), 32'd0);
    check_eq("reset_miso1", 32'(miso1), 32'd0);
    check_eq("reset_strb", 32'(|strb0 | |strb1), 32'd0);
    check_eq("reset_ferr", 32'(ferr0 | ferr1), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_state(0, "reset");
    check_state(1, "reset");

    tx_w[0] = 16'h8005; tx_w[1] = 16'hBEEF;
    run_frame(0, 32, -1, "mode0_write");

    m_rd[1][12] = 16'h1234;
    tx_w[0] = 16'h000C; tx_w[1] = 16'h0000;
    run_frame(1, 32, -1, "mode3_read");

    tx_w[0] = 16'h8030; tx_w[1] = 16'h5A5A;
    run_frame(0, 32, -1, "oor_write");

    tx_w[0] = 16'h8007; tx_w[1] = 16'h1357;
    run_frame(0, 25, -1, "abort");
    tx_w[0] = 16'h8007; tx_w[1] = 16'h2468;
    run_frame(0, 32, -1, "after_abort");

    tx_w[0] = 16'h8001; tx_w[1] = 16'hFFFF;
    run_frame(0, 32, 5, "reset_mid");
    check_state(1, "reset_mid");
    run_frame(0, 32, -1, "after_reset");

    tx_w[0] = 16'h803E; tx_w[1] = 16'h0001; tx_w[2] = 16'h0002; tx_w[3] = 16'h0003;
    run_frame(1, 64, -1, "burst");

    run_frame(1, 0, -1, "empty");
    tx_w[0] = 16'h8003;
    run_frame(0, 16, -1, "hdr_only");

    for (int n = 0; n < 30; n++) begin
      int dev, nw, nbits;
      dev = int'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) m_rd[dev][i] = 16'($urandom);
      tx_w[0] = 16'($urandom);
      nw = int'($urandom_range(0, 3));
      for (int k = 1; k <= nw; k++) tx_w[k] = 16'($urandom);
      nbits = 16 * (nw + 1);
      if ($urandom_range(0, 3) == 0) nbits = int'($urandom_range(1, nbits - 1));
      run_frame(dev, nbits, -1, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
